// File: rtl/uart_rx_core_v2.sv
// UART receiver: 5..DATA_W_MAX data bits, five parity modes, 1/2 stop bits,
// 3-sample majority vote, glitch/break detection, valid/ready output.
module uart_rx_core_v2 #(
    parameter int DATA_W_MAX = 9,
    parameter int BAUD_W     = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_n_i,
    input  logic [3:0]            uart_data_bit,
    input  logic [BAUD_W-1:0]     baud_cnt_max,
    input  logic [2:0]            uart_parity_bit,
    input  logic [1:0]            uart_stop_bit,
    input  logic                  rx_i,
    output logic [DATA_W_MAX-1:0] m_data_o,
    output logic                  m_perr_o,
    output logic                  m_ferr_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  overrun_o,
    output logic                  break_o,
    output logic                  busy_o,
    input  logic                  clr_cnt_i,
    output logic [CNT_W-1:0]      perr_cnt_o,
    output logic [CNT_W-1:0]      ferr_cnt_o,
    output logic [CNT_W-1:0]      ovr_cnt_o
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, BRK
    } state_t;

    localparam logic [3:0] N_MAX = 4'(DATA_W_MAX);

    state_t                  state;
    logic                    rx_m, rx_s, rx_h;
    logic                    start_edge;
    logic [3:0]              n_q, n_in, bit_idx;
    logic [BAUD_W-1:0]       bmax_q, half, baud_cnt;
    logic [2:0]              par_q;
    logic [1:0]              stp_q;
    logic                    par_en, exp_par;
    logic                    smp_a, smp_b, vote, strobe, in_frame;
    logic [DATA_W_MAX-1:0]   data_q;
    logic                    perr_q, ferr_q, zero_q, last_zero;
    logic                    done_q;
    logic                    drop, load;

    // Sync flops idle high so reset never fakes a start edge on an idle line
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_h <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_h <= rx_s;
        end
    end

    assign start_edge = rx_h & ~rx_s;
    assign in_frame   = (state != IDLE) && (state != BRK);
    assign busy_o     = (state != IDLE);
    assign half       = bmax_q >> 1;
    assign par_en     = (par_q != 3'd0) && (par_q <= 3'd4);
    assign vote       = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign strobe     = in_frame && (baud_cnt == half + BAUD_W'(1));
    assign last_zero  = zero_q & ~vote;

    always_comb begin
        n_in = uart_data_bit;
        if (uart_data_bit < 4'd5) n_in = 4'd5;
        else if (uart_data_bit > N_MAX) n_in = N_MAX;
    end

    always_comb begin
        exp_par = 1'b0;
        unique case (par_q)
            3'd1:    exp_par = ~^data_q;
            3'd2:    exp_par = ^data_q;
            3'd3:    exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            baud_cnt <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
        end else begin
            if (!in_frame) baud_cnt <= '0;
            else if (baud_cnt == bmax_q - BAUD_W'(1)) baud_cnt <= '0;
            else baud_cnt <= baud_cnt + BAUD_W'(1);
            if (baud_cnt == half - BAUD_W'(1)) smp_a <= rx_s;
            if (baud_cnt == half) smp_b <= rx_s;
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            n_q     <= 4'd8;
            bmax_q  <= '0;
            par_q   <= '0;
            stp_q   <= '0;
            data_q  <= '0;
            bit_idx <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            break_o <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            break_o <= 1'b0;
            unique case (state)
                IDLE: if (start_edge) begin
                    n_q     <= n_in;
                    bmax_q  <= baud_cnt_max;
                    par_q   <= uart_parity_bit;
                    stp_q   <= uart_stop_bit;
                    data_q  <= '0;
                    bit_idx <= '0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                    zero_q  <= 1'b1;
                    state   <= START;
                end
                START: if (strobe) begin
                    zero_q <= last_zero;
                    state  <= vote ? IDLE : DATA;
                end
                DATA: if (strobe) begin
                    data_q[bit_idx] <= vote;
                    zero_q          <= last_zero;
                    if (bit_idx == n_q - 4'd1) begin
                        bit_idx <= '0;
                        state   <= par_en ? PARITY : STOP1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: if (strobe) begin
                    perr_q <= (vote != exp_par);
                    zero_q <= last_zero;
                    state  <= STOP1;
                end
                STOP1, STOP2: if (strobe) begin
                    ferr_q <= ferr_q | ~vote;
                    zero_q <= last_zero;
                    if (state == STOP1 && stp_q == 2'd2) begin
                        state <= STOP2;
                    end else if (last_zero) begin
                        break_o <= 1'b1;
                        state   <= BRK;
                    end else begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                BRK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // ferr_q still holds the finished frame's flag while done_q is high
    assign drop = done_q & m_valid_o & ~m_ready_i;
    assign load = done_q & ~drop;

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_data_o  <= '0;
            m_perr_o  <= 1'b0;
            m_ferr_o  <= 1'b0;
            m_valid_o <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= drop;
            if (load) begin
                m_data_o  <= data_q;
                m_perr_o  <= perr_q;
                m_ferr_o  <= ferr_q | ~vote & 1'b0;
                m_valid_o <= 1'b1;
            end else if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perr_cnt_o <= '0;
            ferr_cnt_o <= '0;
            ovr_cnt_o  <= '0;
        end else if (clr_cnt_i) begin
            perr_cnt_o <= '0;
            ferr_cnt_o <= '0;
            ovr_cnt_o  <= '0;
        end else begin
            if (load && perr_q && perr_cnt_o != '1)
                perr_cnt_o <= perr_cnt_o + CNT_W'(1);
            if (load && ferr_q && ferr_cnt_o != '1)
                ferr_cnt_o <= ferr_cnt_o + CNT_W'(1);
            if (drop && ovr_cnt_o != '1)
                ovr_cnt_o <= ovr_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_uart_rx_core_v2.sv
// Directed bench for uart_rx_core_v2: framing, parity, stop bits,
// glitch reject, overrun and break.
module tb_uart_rx_core_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  dbits = 4'd8;
    logic [15:0] baud = 16'd16;
    logic [2:0]  pmode = 3'd0;
    logic [1:0]  smode = 2'd0;
    logic        rx = 1'b1;
    logic        ready = 1'b1;
    logic        clr = 1'b0;
    logic [8:0]  m_data;
    logic        m_perr, m_ferr, m_valid, ovr, brk, busy;
    logic [7:0]  perr_cnt, ferr_cnt, ovr_cnt;

    int checks = 0;
    int errors = 0;
    int vcnt = 0;
    int ovr_n = 0;
    int brk_n = 0;
    logic [8:0] ld_data = '0;
    logic       ld_perr = 1'b0;
    logic       ld_ferr = 1'b0;

    uart_rx_core_v2 dut (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .uart_data_bit(dbits), .baud_cnt_max(baud),
        .uart_parity_bit(pmode), .uart_stop_bit(smode),
        .rx_i(rx), .m_data_o(m_data), .m_perr_o(m_perr),
        .m_ferr_o(m_ferr), .m_valid_o(m_valid), .m_ready_i(ready),
        .overrun_o(ovr), .break_o(brk), .busy_o(busy),
        .clr_cnt_i(clr), .perr_cnt_o(perr_cnt),
        .ferr_cnt_o(ferr_cnt), .ovr_cnt_o(ovr_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid) begin
            vcnt++;
            ld_data = m_data;
            ld_perr = m_perr;
            ld_ferr = m_ferr;
        end
        if (ovr) ovr_n++;
        if (brk) brk_n++;
    end

    // pb < 0 means no parity bit; otherwise its value
    function automatic logic [15:0] mkf(input logic [8:0] d, input int n,
                                        input int pb, input int ns,
                                        input logic s2v);
        logic [15:0] f;
        int k;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < n; i++) f[1+i] = d[i];
        k = 1 + n;
        if (pb >= 0) begin
            f[k] = pb[0];
            k++;
        end
        f[k] = 1'b1;
        if (ns == 2) f[k+1] = s2v;
        return f;
    endfunction

    task automatic tx_frame(input logic [15:0] f, input int nb, input int b);
        @(posedge clk); #1;
        for (int i = 0; i < nb; i++) begin
            rx = f[i];
            if (i < nb - 1) begin
                repeat (b) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send(input logic [8:0] d, input int n, input int pb,
                        input int ns, input logic s2v, input int b);
        int nb;
        nb = 1 + n + ((pb >= 0) ? 1 : 0) + ns;
        tx_frame(mkf(d, n, pb, ns, s2v), nb, b);
        repeat (b) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * b) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic cfg(input int n, input int b, input int p, input int s);
        dbits = 4'(n);
        baud  = 16'(b);
        pmode = 3'(p);
        smode = 2'(s);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, m_data, m_perr, m_ferr, ovr, brk, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_out: got %h exp 0",
                     {m_valid, m_data, m_perr, m_ferr, ovr, brk, busy});
        end
        checks++;
        if ({perr_cnt, ferr_cnt, ovr_cnt} !== 24'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %h exp 0", {perr_cnt, ferr_cnt, ovr_cnt});
        end
    endtask

    task automatic test_8n1();
        int v0;
        cfg(8, 16, 0, 0);
        ready = 1'b1;
        v0 = vcnt;
        tx_frame(mkf(9'h0A5, 8, -1, 1, 1'b1), 10, 16);
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_early: valid got %b exp 0", m_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({m_valid, m_data, m_perr, m_ferr} !== {1'b1, 9'h0A5, 2'b00}) begin
            errors++;
            $display("FAIL 8n1_word: got v=%b d=%h p=%b f=%b exp v=1 d=0a5 p=0 f=0",
                     m_valid, m_data, m_perr, m_ferr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_busy: got %b exp 0", busy);
        end
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_drop: valid got %b exp 0", m_valid);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (vcnt - v0 !== 1) begin
            errors++;
            $display("FAIL 8n1_cycles: valid cycles got %0d exp 1", vcnt - v0);
        end
    endtask

    task automatic test_parity();
        clear_counters();
        cfg(7, 8, 2, 0);
        send(9'h041, 7, 1, 1, 1'b1, 8);
        checks++;
        if ({ld_data, ld_perr, ld_ferr} !== {9'h041, 2'b10}) begin
            errors++;
            $display("FAIL par_word: got d=%h p=%b f=%b exp d=041 p=1 f=0",
                     ld_data, ld_perr, ld_ferr);
        end
        checks++;
        if (perr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL par_cnt1: got %0d exp 1", perr_cnt);
        end
        for (int i = 0; i < 255; i++) send(9'h041, 7, 1, 1, 1'b1, 8);
        checks++;
        if (perr_cnt !== 8'd255) begin
            errors++;
            $display("FAIL par_sat: got %0d exp 255", perr_cnt);
        end
        checks++;
        if (ferr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL par_ferr: got %0d exp 0", ferr_cnt);
        end
    endtask

    task automatic test_stop2();
        clear_counters();
        checks++;
        if (perr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_cnt: perr got %0d exp 0", perr_cnt);
        end
        cfg(9, 16, 3, 2);
        send(9'h1FF, 9, 1, 2, 1'b0, 16);
        checks++;
        if ({ld_data, ld_perr, ld_ferr} !== {9'h1FF, 2'b01}) begin
            errors++;
            $display("FAIL stop2_word: got d=%h p=%b f=%b exp d=1ff p=0 f=1",
                     ld_data, ld_perr, ld_ferr);
        end
        checks++;
        if ({ferr_cnt, perr_cnt} !== {8'd1, 8'd0}) begin
            errors++;
            $display("FAIL stop2_cnt: got ferr=%0d perr=%0d exp 1 0",
                     ferr_cnt, perr_cnt);
        end
    endtask

    task automatic test_glitch();
        int v0;
        clear_counters();
        cfg(8, 16, 0, 0);
        v0 = vcnt;
        @(posedge clk); #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_hi: got %b exp 1", busy);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_lo: got %b exp 0", busy);
        end
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (vcnt - v0 !== 0) begin
            errors++;
            $display("FAIL glitch_valid: cycles got %0d exp 0", vcnt - v0);
        end
        checks++;
        if ({perr_cnt, ferr_cnt, ovr_cnt} !== 24'd0) begin
            errors++;
            $display("FAIL glitch_cnt: got %h exp 0", {perr_cnt, ferr_cnt, ovr_cnt});
        end
    endtask

    task automatic test_overrun();
        int o0;
        clear_counters();
        cfg(8, 16, 0, 0);
        ready = 1'b0;
        o0 = ovr_n;
        send(9'h011, 8, -1, 1, 1'b1, 16);
        checks++;
        if ({m_valid, m_data} !== {1'b1, 9'h011}) begin
            errors++;
            $display("FAIL ovr_first: got v=%b d=%h exp v=1 d=011", m_valid, m_data);
        end
        send(9'h022, 8, -1, 1, 1'b1, 16);
        checks++;
        if ({m_valid, m_data} !== {1'b1, 9'h011}) begin
            errors++;
            $display("FAIL ovr_hold: got v=%b d=%h exp v=1 d=011", m_valid, m_data);
        end
        checks++;
        if (ovr_n - o0 !== 1) begin
            errors++;
            $display("FAIL ovr_pulse: got %0d exp 1", ovr_n - o0);
        end
        checks++;
        if (ovr_cnt !== 8'd1) begin
            errors++;
            $display("FAIL ovr_cnt: got %0d exp 1", ovr_cnt);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_accept: valid got %b exp 0", m_valid);
        end
    endtask

    task automatic test_break();
        int v0, b0;
        clear_counters();
        cfg(8, 16, 0, 0);
        ready = 1'b1;
        v0 = vcnt;
        b0 = brk_n;
        @(posedge clk); #1 rx = 1'b0;
        repeat (12 * 16) @(posedge clk);
        #1 rx = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        checks++;
        if (brk_n - b0 !== 1) begin
            errors++;
            $display("FAIL brk_pulse: got %0d exp 1", brk_n - b0);
        end
        checks++;
        if (vcnt - v0 !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL brk_noword: cycles=%0d busy=%b exp 0 0", vcnt - v0, busy);
        end
        checks++;
        if ({perr_cnt, ferr_cnt} !== 16'd0) begin
            errors++;
            $display("FAIL brk_cnt: got %h exp 0", {perr_cnt, ferr_cnt});
        end
        send(9'h05A, 8, -1, 1, 1'b1, 16);
        checks++;
        if (vcnt - v0 !== 1 || {ld_data, ld_perr, ld_ferr} !== {9'h05A, 2'b00}) begin
            errors++;
            $display("FAIL brk_after: cycles=%0d d=%h p=%b f=%b exp 1 05a 0 0",
                     vcnt - v0, ld_data, ld_perr, ld_ferr);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop2();
        test_glitch();
        test_overrun();
        test_break();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
